// File: rtl/rename_resolver.sv
// rename_resolver: N-way register renaming with intra-bundle forwarding, a free-tag pool, commit reclaim and flush.
// Define RENAME_COMMIT_BYPASS_EN to let tags released by this cycle's commits be allocated in the same cycle.
module rename_resolver #(
  parameter int WAYS      = 2,
  parameter int ARCH_REGS = 32,
  parameter int TAGS      = 64,
  parameter int COMMITS   = 2,
  parameter int PAYLOAD_W = 96,
  localparam int AW       = $clog2(ARCH_REGS),
  localparam int TAG_W    = $clog2(TAGS),
  localparam int CNT_W    = $clog2(TAGS) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WAYS-1:0]                    in_way_valid,
  input  logic [WAYS-1:0][AW-1:0]            in_src1,
  input  logic [WAYS-1:0][AW-1:0]            in_src2,
  input  logic [WAYS-1:0][AW-1:0]            in_dest,
  input  logic [WAYS-1:0][PAYLOAD_W-1:0]     in_payload,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WAYS-1:0]                    out_way_valid,
  output logic [WAYS-1:0][TAG_W-1:0]         out_src1_tag,
  output logic [WAYS-1:0][TAG_W-1:0]         out_src2_tag,
  output logic [WAYS-1:0]                    out_src1_ren,
  output logic [WAYS-1:0]                    out_src2_ren,
  output logic [WAYS-1:0][TAG_W-1:0]         out_dest_tag,
  output logic [WAYS-1:0][PAYLOAD_W-1:0]     out_payload,
  input  logic [COMMITS-1:0]                 commit_valid,
  input  logic [COMMITS-1:0][TAG_W-1:0]      commit_tag,
  input  logic [COMMITS-1:0][AW-1:0]         commit_arch,
  output logic [CNT_W-1:0]                   free_count
);

  function automatic logic [CNT_W-1:0] popcount(input logic [TAGS-1:0] v);
    popcount = '0;
    for (int i = 0; i < TAGS; i++) popcount += CNT_W'(v[i]);
  endfunction

  logic [ARCH_REGS-1:0][TAG_W-1:0]    rat_tag_q, rat_tag_d;
  logic [ARCH_REGS-1:0]               rat_ren_q, rat_ren_d;
  logic [TAGS-1:0]                    free_q, free_d;
  logic [CNT_W-1:0]                   free_count_q, free_count_d;
  logic                               out_valid_q, out_valid_d;
  logic [WAYS-1:0]                    out_way_valid_q, out_way_valid_d;
  logic [WAYS-1:0][TAG_W-1:0]         out_src1_tag_q, out_src1_tag_d;
  logic [WAYS-1:0][TAG_W-1:0]         out_src2_tag_q, out_src2_tag_d;
  logic [WAYS-1:0]                    out_src1_ren_q, out_src1_ren_d;
  logic [WAYS-1:0]                    out_src2_ren_q, out_src2_ren_d;
  logic [WAYS-1:0][TAG_W-1:0]         out_dest_tag_q, out_dest_tag_d;
  logic [WAYS-1:0][PAYLOAD_W-1:0]     out_payload_q, out_payload_d;

  logic [WAYS-1:0]                    writes;
  logic [CNT_W-1:0]                   need, avail;
  logic [TAGS-1:0]                    commit_mask, pool, alloc_pool, alloc_mask;
  logic [WAYS-1:0][TAG_W-1:0]         alloc_tag;
  logic                               found;
  logic                               accept;
  logic [WAYS-1:0][TAG_W-1:0]         src1_tag, src2_tag;
  logic [WAYS-1:0]                    src1_ren, src2_ren;
  logic [AW-1:0]                      src_a;
  logic [TAG_W-1:0]                   s_tag;
  logic                               s_ren;

  // Commits of tags that are already free are dropped entirely.
  always_comb begin
    writes      = '0;
    need        = '0;
    commit_mask = '0;
    for (int w = 0; w < WAYS; w++) begin
      writes[w] = in_way_valid[w] && (in_dest[w] != '0);
      need     += CNT_W'(writes[w]);
    end
    for (int p = 0; p < COMMITS; p++)
      if (commit_valid[p] && !free_q[commit_tag[p]]) commit_mask[commit_tag[p]] = 1'b1;
`ifdef RENAME_COMMIT_BYPASS_EN
    pool  = free_q | commit_mask;
    avail = popcount(pool);
`else
    pool  = free_q;
    avail = free_count_q;
`endif
    alloc_pool = pool;
    alloc_mask = '0;
    alloc_tag  = '0;
    found      = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      found = 1'b0;
      if (writes[w]) begin
        for (int t = 0; t < TAGS; t++) begin
          if (!found && alloc_pool[t]) begin
            alloc_tag[w] = TAG_W'(t);
            found        = 1'b1;
          end
        end
        if (found) begin
          alloc_pool[alloc_tag[w]] = 1'b0;
          alloc_mask[alloc_tag[w]] = 1'b1;
        end
      end
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && (need <= avail) && !flush;
  assign accept   = in_valid && in_ready;

  // Nearest earlier writer in the bundle overrides the RAT; x0 is never renamed.
  always_comb begin
    src1_tag = '0;
    src2_tag = '0;
    src1_ren = '0;
    src2_ren = '0;
    src_a    = '0;
    s_tag    = '0;
    s_ren    = 1'b0;
    for (int j = 0; j < WAYS; j++) begin
      for (int k = 0; k < 2; k++) begin
        src_a = (k == 0) ? in_src1[j] : in_src2[j];
        s_ren = rat_ren_q[src_a];
        s_tag = rat_ren_q[src_a] ? rat_tag_q[src_a] : '0;
        for (int i = 0; i < j; i++) begin
          if (writes[i] && (in_dest[i] == src_a)) begin
            s_tag = alloc_tag[i];
            s_ren = 1'b1;
          end
        end
        if (src_a == '0) begin
          s_tag = '0;
          s_ren = 1'b0;
        end
        if (k == 0) begin
          src1_tag[j] = s_tag;
          src1_ren[j] = s_ren;
        end else begin
          src2_tag[j] = s_tag;
          src2_ren[j] = s_ren;
        end
      end
    end
  end

  // Commit clears are applied first so a same-cycle rename of that arch reg wins.
  always_comb begin
    rat_tag_d = rat_tag_q;
    rat_ren_d = rat_ren_q;
    free_d    = free_q | commit_mask;
    for (int p = 0; p < COMMITS; p++) begin
      if (commit_valid[p] && !free_q[commit_tag[p]] && rat_ren_q[commit_arch[p]] &&
          (rat_tag_q[commit_arch[p]] == commit_tag[p]))
        rat_ren_d[commit_arch[p]] = 1'b0;
    end
    out_valid_d     = out_valid_q && !out_ready;
    out_way_valid_d = out_way_valid_q;
    out_src1_tag_d  = out_src1_tag_q;
    out_src2_tag_d  = out_src2_tag_q;
    out_src1_ren_d  = out_src1_ren_q;
    out_src2_ren_d  = out_src2_ren_q;
    out_dest_tag_d  = out_dest_tag_q;
    out_payload_d   = out_payload_q;
    if (accept) begin
      free_d = free_d & ~alloc_mask;
      for (int w = 0; w < WAYS; w++) begin
        if (writes[w]) begin
          rat_tag_d[in_dest[w]] = alloc_tag[w];
          rat_ren_d[in_dest[w]] = 1'b1;
        end
      end
      out_valid_d     = 1'b1;
      out_way_valid_d = in_way_valid;
      out_src1_tag_d  = src1_tag;
      out_src2_tag_d  = src2_tag;
      out_src1_ren_d  = src1_ren;
      out_src2_ren_d  = src2_ren;
      out_dest_tag_d  = alloc_tag;
      out_payload_d   = in_payload;
    end
    if (flush) begin
      rat_tag_d   = '0;
      rat_ren_d   = '0;
      free_d      = '1;
      out_valid_d = 1'b0;
    end
    free_count_d = popcount(free_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rat_tag_q       <= '0;
      rat_ren_q       <= '0;
      free_q          <= '1;
      free_count_q    <= CNT_W'(TAGS);
      out_valid_q     <= 1'b0;
      out_way_valid_q <= '0;
      out_src1_tag_q  <= '0;
      out_src2_tag_q  <= '0;
      out_src1_ren_q  <= '0;
      out_src2_ren_q  <= '0;
      out_dest_tag_q  <= '0;
      out_payload_q   <= '0;
    end else begin
      rat_tag_q       <= rat_tag_d;
      rat_ren_q       <= rat_ren_d;
      free_q          <= free_d;
      free_count_q    <= free_count_d;
      out_valid_q     <= out_valid_d;
      out_way_valid_q <= out_way_valid_d;
      out_src1_tag_q  <= out_src1_tag_d;
      out_src2_tag_q  <= out_src2_tag_d;
      out_src1_ren_q  <= out_src1_ren_d;
      out_src2_ren_q  <= out_src2_ren_d;
      out_dest_tag_q  <= out_dest_tag_d;
      out_payload_q   <= out_payload_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_way_valid = out_way_valid_q;
  assign out_src1_tag  = out_src1_tag_q;
  assign out_src2_tag  = out_src2_tag_q;
  assign out_src1_ren  = out_src1_ren_q;
  assign out_src2_ren  = out_src2_ren_q;
  assign out_dest_tag  = out_dest_tag_q;
  assign out_payload   = out_payload_q;
  assign free_count    = free_count_q;

  for (genvar p = 0; p < COMMITS; p++) begin : g_commit_chk
    a_commit_not_free: assert property (@(posedge clk) disable iff (reset)
      !(commit_valid[p] && free_q[commit_tag[p]]));
  end

endmodule
